// File: rtl/vga_clock_time_ctrl.sv
// Timekeeping and button-adjust controller for the vga_clock renderer.
// Divides wb_clk_i to 1 Hz, keeps 24 h BCD time and sequences the three adjust buttons.
//
// Button FSM (hrs, min):
//   state         | meaning
//   BTN_RELEASED  | debounced level low, waiting for a press
//   BTN_HOLD      | pressed, first pulse sent, counting down the repeat delay
//   BTN_REPEAT    | held past the delay, one pulse per repeat period
module vga_clock_time_ctrl #(
  parameter int unsigned CLK_HZ          = 31_500_000,
  parameter int unsigned DEBOUNCE_CYCLES = 65_536,
  parameter int unsigned REPEAT_DELAY    = 15_750_000,
  parameter int unsigned REPEAT_PERIOD   = 3_150_000
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       run,
  input  logic       adj_hrs,
  input  logic       adj_min,
  input  logic       adj_sec,
  output logic [1:0] hrs_tens,
  output logic [3:0] hrs_units,
  output logic [2:0] min_tens,
  output logic [3:0] min_units,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       sec_tick
);

  localparam int unsigned PRESC_W = $clog2(CLK_HZ);
  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(CLK_HZ - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0]   DELAY_LOAD  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0]   PERIOD_LOAD = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    BTN_RELEASED,
    BTN_HOLD,
    BTN_REPEAT
  } btn_state_e;

  // bit 0 = hrs, bit 1 = min, bit 2 = sec
  logic [2:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]         deb_q, deb_d, rise, fall;
  logic [DEB_W-1:0]   deb_cnt_q [3];
  logic [DEB_W-1:0]   deb_cnt_d [3];
  btn_state_e         btn_state_q [2];
  btn_state_e         btn_state_d [2];
  logic [REP_W-1:0]   rep_cnt_q [2];
  logic [REP_W-1:0]   rep_cnt_d [2];
  logic [1:0]         rep_pulse;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [1:0]         hrs_tens_q, hrs_tens_d;
  logic [3:0]         hrs_units_q, hrs_units_d;
  logic [2:0]         min_tens_q, min_tens_d;
  logic [3:0]         min_units_q, min_units_d;
  logic [2:0]         sec_tens_q, sec_tens_d;
  logic [3:0]         sec_units_q, sec_units_d;
  logic               sec_tick_q, sec_tick_d;

  logic hrs_pulse, min_pulse, sec_pulse;
  logic tick_ev, sec_carry, min_carry;

  function automatic logic [6:0] inc_mod60(input logic [2:0] t, input logic [3:0] u);
    if (u == 4'd9) begin
      if (t == 3'd5) return 7'd0;
      return {t + 3'd1, 4'd0};
    end
    return {t, u + 4'd1};
  endfunction

  function automatic logic [5:0] inc_mod24(input logic [1:0] t, input logic [3:0] u);
    if (t == 2'd2 && u == 4'd3) return 6'd0;
    if (u == 4'd9) return {t + 2'd1, 4'd0};
    return {t, u + 4'd1};
  endfunction

  always_comb begin
    sync1_d = {adj_sec, adj_min, adj_hrs};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
      end
    end
    // Edges are taken from the level about to be registered so the pulse lands on the flip edge
    rise = deb_d & ~deb_q;
    fall = ~deb_d & deb_q;
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      btn_state_d[i] = btn_state_q[i];
      rep_cnt_d[i]   = rep_cnt_q[i];
      rep_pulse[i]   = 1'b0;
      if (fall[i]) begin
        btn_state_d[i] = BTN_RELEASED;
        rep_cnt_d[i]   = '0;
      end else begin
        case (btn_state_q[i])
          BTN_RELEASED: begin
            if (rise[i]) begin
              btn_state_d[i] = BTN_HOLD;
              rep_pulse[i]   = 1'b1;
              rep_cnt_d[i]   = DELAY_LOAD;
            end
          end
          BTN_HOLD: begin
            if (rep_cnt_q[i] == '0) begin
              btn_state_d[i] = BTN_REPEAT;
              rep_pulse[i]   = 1'b1;
              rep_cnt_d[i]   = PERIOD_LOAD;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] - REP_W'(1);
            end
          end
          BTN_REPEAT: begin
            if (rep_cnt_q[i] == '0) begin
              rep_pulse[i] = 1'b1;
              rep_cnt_d[i] = PERIOD_LOAD;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] - REP_W'(1);
            end
          end
          default: begin
            btn_state_d[i] = BTN_RELEASED;
            rep_cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  assign hrs_pulse = rep_pulse[0];
  assign min_pulse = rep_pulse[1];
  assign sec_pulse = rise[2];

  always_comb begin
    tick_ev   = run && (presc_q == PRESC_LAST) && !sec_pulse;
    sec_carry = tick_ev && (sec_tens_q == 3'd5) && (sec_units_q == 4'd9);
    min_carry = sec_carry && !min_pulse && (min_tens_q == 3'd5) && (min_units_q == 4'd9);

    presc_d = presc_q;
    if (sec_pulse)                   presc_d = '0;
    else if (run && tick_ev)         presc_d = '0;
    else if (run)                    presc_d = presc_q + PRESC_W'(1);

    {sec_tens_d, sec_units_d} = {sec_tens_q, sec_units_q};
    if (sec_pulse)    {sec_tens_d, sec_units_d} = 7'd0;
    else if (tick_ev) {sec_tens_d, sec_units_d} = inc_mod60(sec_tens_q, sec_units_q);

    // An adjust on a field wins over any carry into it; that carry is dropped
    {min_tens_d, min_units_d} = {min_tens_q, min_units_q};
    if (min_pulse || sec_carry) {min_tens_d, min_units_d} = inc_mod60(min_tens_q, min_units_q);

    {hrs_tens_d, hrs_units_d} = {hrs_tens_q, hrs_units_q};
    if (hrs_pulse || min_carry) {hrs_tens_d, hrs_units_d} = inc_mod24(hrs_tens_q, hrs_units_q);

    sec_tick_d = tick_ev;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      presc_q     <= '0;
      hrs_tens_q  <= '0;
      hrs_units_q <= '0;
      min_tens_q  <= '0;
      min_units_q <= '0;
      sec_tens_q  <= '0;
      sec_units_q <= '0;
      sec_tick_q  <= 1'b0;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
      for (int i = 0; i < 2; i++) begin
        btn_state_q[i] <= BTN_RELEASED;
        rep_cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      presc_q     <= presc_d;
      hrs_tens_q  <= hrs_tens_d;
      hrs_units_q <= hrs_units_d;
      min_tens_q  <= min_tens_d;
      min_units_q <= min_units_d;
      sec_tens_q  <= sec_tens_d;
      sec_units_q <= sec_units_d;
      sec_tick_q  <= sec_tick_d;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      for (int i = 0; i < 2; i++) begin
        btn_state_q[i] <= btn_state_d[i];
        rep_cnt_q[i]   <= rep_cnt_d[i];
      end
    end
  end

  assign hrs_tens  = hrs_tens_q;
  assign hrs_units = hrs_units_q;
  assign min_tens  = min_tens_q;
  assign min_units = min_units_q;
  assign sec_tens  = sec_tens_q;
  assign sec_units = sec_units_q;
  assign sec_tick  = sec_tick_q;

endmodule

// File: tb/tb_vga_clock_time_ctrl.sv
// Directed bench for vga_clock_time_ctrl with small timing parameters.
// Time is compared as a decimal hhmmss number built from the six BCD digits.
module tb_vga_clock_time_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       adj_hrs = 1'b0, adj_min = 1'b0, adj_sec = 1'b0;
  logic [1:0] hrs_tens;
  logic [3:0] hrs_units;
  logic [2:0] min_tens;
  logic [3:0] min_units;
  logic [2:0] sec_tens;
  logic [3:0] sec_units;
  logic       sec_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt;

  vga_clock_time_ctrl #(
    .CLK_HZ(10), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .run(run),
    .adj_hrs(adj_hrs), .adj_min(adj_min), .adj_sec(adj_sec),
    .hrs_tens(hrs_tens), .hrs_units(hrs_units),
    .min_tens(min_tens), .min_units(min_units),
    .sec_tens(sec_tens), .sec_units(sec_units),
    .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int hms();
    return int'(hrs_tens) * 100000 + int'(hrs_units) * 10000 + int'(min_tens) * 1000 +
           int'(min_units) * 100 + int'(sec_tens) * 10 + int'(sec_units);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: adj_hrs = v;
      1: adj_min = v;
      default: adj_sec = v;
    endcase
  endtask

  // Hold a button for n cycles, then release and let the fall debounce out
  task automatic press(input int b, input int n);
    set_btn(b, 1'b1);
    cycles(n);
    set_btn(b, 1'b0);
    cycles(12);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
  endtask

  initial begin
    cycles(2);
    chk("reset_time", hms(), 0);
    chk("reset_tick", int'(sec_tick), 0);
    rst = 1'b0;
    run = 1'b1;

    // 1: first second and first minute
    tick_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) chk("t1_pre_tick_time", hms(), 0);
      cycles(1);
      tick_cnt += int'(sec_tick);
    end
    chk("t1_one_sec", hms(), 1);
    chk("t1_tick_high", int'(sec_tick), 1);
    chk("t1_tick_count", tick_cnt, 1);
    cycles(1);
    chk("t1_tick_low", int'(sec_tick), 0);
    cycles(589);
    chk("t1_one_min", hms(), 100);

    // 2: reach 23:59:59 through the buttons, then roll over
    run = 1'b0;
    press(0, 128);
    chk("t2_hrs23", hms(), 230100);
    press(1, 303);
    chk("t2_min59", hms(), 235900);
    run = 1'b1;
    cycles(590);
    chk("t2_235959", hms(), 235959);
    cycles(9);
    chk("t2_before_wrap", hms(), 235959);
    chk("t2_before_wrap_tick", int'(sec_tick), 0);
    cycles(1);
    chk("t2_wrap", hms(), 0);
    chk("t2_wrap_tick", int'(sec_tick), 1);
    cycles(1);
    chk("t2_wrap_tick_low", int'(sec_tick), 0);

    // 3: glitch rejected, clean press counted once
    run = 1'b0;
    adj_min = 1'b1;
    cycles(3);
    adj_min = 1'b0;
    cycles(10);
    chk("t3_glitch", hms(), 0);
    adj_min = 1'b1;
    cycles(5);
    chk("t3_before_pulse", hms(), 0);
    cycles(1);
    chk("t3_pulse", hms(), 100);
    cycles(2);
    adj_min = 1'b0;
    cycles(30);
    chk("t3_released", hms(), 100);

    // 4: hours auto-repeat through the 23->00 wrap
    do_reset();
    chk("t4_reset", hms(), 0);
    press(0, 123);
    chk("t4_hrs22", hms(), 220000);
    adj_hrs = 1'b1;
    cycles(5);
    chk("t4_no_pulse_yet", hms(), 220000);
    cycles(1);
    chk("t4_first", hms(), 230000);
    cycles(19);
    chk("t4_delay", hms(), 230000);
    cycles(1);
    chk("t4_repeat_wrap", hms(), 0);
    cycles(5);
    chk("t4_repeat2", hms(), 10000);
    cycles(29);
    chk("t4_repeat_run", hms(), 60000);
    adj_hrs = 1'b0;
    cycles(12);
    chk("t4_final", hms(), 70000);

    // 5a: seconds clear at prescaler 7
    do_reset();
    run = 1'b1;
    cycles(422);
    chk("t5_42s", hms(), 42);
    adj_sec = 1'b1;
    cycles(5);
    chk("t5_before_clr", hms(), 42);
    cycles(1);
    chk("t5_clr", hms(), 0);
    chk("t5_clr_tick", int'(sec_tick), 0);
    cycles(9);
    chk("t5_no_early_tick", int'(sec_tick), 0);
    chk("t5_no_early_time", hms(), 0);
    cycles(1);
    chk("t5_tick_after10", int'(sec_tick), 1);
    chk("t5_time_after10", hms(), 1);
    adj_sec = 1'b0;
    cycles(12);

    // 5b: minute adjust coincident with the seconds carry
    do_reset();
    run = 1'b0;
    press(0, 73);
    press(1, 183);
    chk("t5_1234", hms(), 123400);
    run = 1'b1;
    cycles(590);
    chk("t5_123459", hms(), 123459);
    cycles(4);
    adj_min = 1'b1;
    cycles(5);
    chk("t5_pre_coinc", hms(), 123459);
    cycles(1);
    chk("t5_coinc", hms(), 123500);
    chk("t5_coinc_tick", int'(sec_tick), 1);
    adj_min = 1'b0;
    cycles(12);

    // 6: reset in REPEAT, button must re-debounce
    do_reset();
    run = 1'b0;
    adj_hrs = 1'b1;
    cycles(30);
    chk("t6_in_repeat", hms(), 20000);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("t6_reset", hms(), 0);
    cycles(5);
    chk("t6_no_pulse", hms(), 0);
    cycles(1);
    chk("t6_redebounced", hms(), 10000);
    adj_hrs = 1'b0;
    cycles(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
